// File: rtl/ldpc_pkg.sv
// Shared types and helpers for the LDPC check-node datapath.
//  BITS      message width (two's complement)
//  P_DEFAULT default lane count per beat
//  DEG_MAX   maximum row degree (elements per frame)
//  IDXW      width of an element index within a row
//  mag_t     saturated magnitude, BITS-1 bits
//  min2_t    check-node summary: min1, min2, index of min1, sign parity
package ldpc_pkg;

  localparam int BITS      = 8;
  localparam int P_DEFAULT = 4;
  localparam int DEG_MAX   = 32;
  localparam int IDXW      = $clog2(DEG_MAX);

  typedef logic [BITS-2:0] mag_t;

  localparam mag_t MAG_MAX = '1;

  typedef struct packed {
    mag_t            min1;
    mag_t            min2;
    logic [IDXW-1:0] idx1;
    logic            sign;
  } min2_t;

  localparam min2_t MIN2_INIT = '{min1: MAG_MAX, min2: MAG_MAX, idx1: '0, sign: 1'b0};

  // |x| folded into BITS-1 bits; the most negative code has no positive
  // counterpart and is clamped to MAG_MAX.
  function automatic mag_t sat_abs(input logic [BITS-1:0] x);
    logic [BITS-1:0] neg;
    neg = -x;
    if (!x[BITS-1]) begin
      return x[BITS-2:0];
    end else if (neg[BITS-1]) begin
      return MAG_MAX;
    end else begin
      return neg[BITS-2:0];
    end
  endfunction

  function automatic mag_t mag_min(input mag_t a, input mag_t b);
    return (b < a) ? b : a;
  endfunction

endpackage

// File: rtl/cn_min2_stream_if.sv
// Beat-in / result-out bundle of the streaming check-node kernel.
//  in_valid/in_ready/in_data/in_mask/in_last : one beat of P messages
//  out_valid/out_ready                        : result handshake
//  out_min1/out_min2/out_idx1/out_sign/out_ovf: per-frame result
//  master = producer of beats and consumer of results, slave = the kernel.
interface cn_min2_stream_if
  import ldpc_pkg::*;
#(
  parameter int P = P_DEFAULT
) ();

  logic                     in_valid;
  logic                     in_ready;
  logic [P-1:0][BITS-1:0]   in_data;
  logic [P-1:0]             in_mask;
  logic                     in_last;

  logic                     out_valid;
  logic                     out_ready;
  mag_t                     out_min1;
  mag_t                     out_min2;
  logic [IDXW-1:0]          out_idx1;
  logic                     out_sign;
  logic                     out_ovf;

  modport master (
    output in_valid, in_data, in_mask, in_last, out_ready,
    input  in_ready, out_valid, out_min1, out_min2, out_idx1, out_sign, out_ovf
  );

  modport slave (
    input  in_valid, in_data, in_mask, in_last, out_ready,
    output in_ready, out_valid, out_min1, out_min2, out_idx1, out_sign, out_ovf
  );

endinterface

// File: rtl/cn_min2_tree.sv
// Combinational min1/min2/argmin over N masked lanes.
//  data  in  N signed messages
//  mask  in  1 = lane carries an element
//  min1  out smallest magnitude (MAG_MAX if no lane is unmasked)
//  min2  out second-smallest magnitude
//  idx   out lane of min1 (lower lane wins ties)
//  sign  out XOR of the signs of unmasked lanes
// Recursive: N splits into the largest power of two below N plus the rest,
// so any N >= 1 is handled.
module cn_min2_tree
  import ldpc_pkg::*;
#(
  parameter int N  = 4,
  parameter int LW = 2
) (
  input  logic [N-1:0][BITS-1:0] data,
  input  logic [N-1:0]           mask,
  output mag_t                   min1,
  output mag_t                   min2,
  output logic [LW-1:0]          idx,
  output logic                   sign
);

  generate
    if (N == 1) begin : g_leaf
      // A masked lane looks like an empty slot: MAG_MAX never beats anything.
      assign min1 = mask[0] ? sat_abs(data[0]) : MAG_MAX;
      assign min2 = MAG_MAX;
      assign idx  = '0;
      assign sign = mask[0] & data[0][BITS-1];
    end else begin : g_node
      localparam int L = 1 << ($clog2(N) - 1);
      localparam int R = N - L;

      mag_t          l_min1, l_min2, r_min1, r_min2;
      logic [LW-1:0] l_idx, r_idx;
      logic          l_sign, r_sign;

      cn_min2_tree #(.N(L), .LW(LW)) u_left (
        .data (data[L-1:0]),
        .mask (mask[L-1:0]),
        .min1 (l_min1),
        .min2 (l_min2),
        .idx  (l_idx),
        .sign (l_sign)
      );

      cn_min2_tree #(.N(R), .LW(LW)) u_right (
        .data (data[N-1:L]),
        .mask (mask[N-1:L]),
        .min1 (r_min1),
        .min2 (r_min2),
        .idx  (r_idx),
        .sign (r_sign)
      );

      // Right side must be strictly smaller to win, which keeps the lower lane on ties.
      always_comb begin
        if (r_min1 < l_min1) begin
          min1 = r_min1;
          idx  = r_idx + LW'(L);
          min2 = mag_min(l_min1, mag_min(l_min2, r_min2));
        end else begin
          min1 = l_min1;
          idx  = l_idx;
          min2 = mag_min(r_min1, mag_min(l_min2, r_min2));
        end
      end

      assign sign = l_sign ^ r_sign;
    end
  endgenerate

endmodule

// File: rtl/cn_min2_stream.sv
// Streaming min-sum check-node kernel.
//  clk, rst : clock and synchronous active-high reset
//  bus      : cn_min2_stream_if.slave -- beats of P messages in, one
//             {min1, min2, idx1, sign, ovf} result per frame out.
// Each accepted beat is reduced by cn_min2_tree and merged into the running
// accumulator in the same cycle. The beat carrying in_last loads the merged
// value into a single-entry output register and re-initialises the
// accumulator, so consecutive frames stream without a bubble.
module cn_min2_stream
  import ldpc_pkg::*;
#(
  parameter int P = P_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  cn_min2_stream_if.slave bus
);

  localparam int LW        = (P > 1) ? $clog2(P) : 1;
  localparam int BEATS_MAX = (DEG_MAX + P - 1) / P;   // first beat lying wholly past DEG_MAX
  localparam int CW        = $clog2(BEATS_MAX + 1);
  localparam int EW        = CW + LW + 1;             // holds beat*P + lane without wrap

  mag_t            b_min1, b_min2;
  logic [LW-1:0]   b_lane;
  logic            b_sign;

  logic [CW-1:0]   beat_cnt_reg, beat_cnt_next;
  min2_t           acc_reg, merged, out_reg;
  logic            acc_ovf_reg, merged_ovf, out_ovf_reg, out_valid_reg;
  logic [EW-1:0]   beat_base, b_elem;
  logic [P-1:0]    lane_over;
  logic [IDXW-1:0] b_idx;
  mag_t            loser;
  logic            in_ready_int, accept;

  cn_min2_tree #(.N(P), .LW(LW)) u_tree (
    .data (bus.in_data),
    .mask (bus.in_mask),
    .min1 (b_min1),
    .min2 (b_min2),
    .idx  (b_lane),
    .sign (b_sign)
  );

  assign beat_base = EW'(beat_cnt_reg) * EW'(P);

  // Any unmasked lane whose element number reaches DEG_MAX flags overflow.
  generate
    for (genvar gi = 0; gi < P; gi++) begin : g_lane
      assign lane_over[gi] = bus.in_mask[gi] && ((beat_base + EW'(gi)) >= EW'(DEG_MAX));
    end
  endgenerate

  // Out-of-range elements still compete, but report the last legal index.
  assign b_elem = beat_base + EW'(b_lane);
  assign b_idx  = (b_elem >= EW'(DEG_MAX)) ? IDXW'(DEG_MAX - 1) : b_elem[IDXW-1:0];

  // Accumulator holds earlier elements, so it keeps min1 on a tie.
  always_comb begin
    merged = acc_reg;
    loser  = b_min1;
    if (b_min1 < acc_reg.min1) begin
      merged.min1 = b_min1;
      merged.idx1 = b_idx;
      loser       = acc_reg.min1;
    end
    merged.min2 = mag_min(loser, mag_min(acc_reg.min2, b_min2));
    merged.sign = acc_reg.sign ^ b_sign;
  end

  assign merged_ovf    = acc_ovf_reg | (|lane_over);
  assign beat_cnt_next = (beat_cnt_reg == CW'(BEATS_MAX)) ? beat_cnt_reg : beat_cnt_reg + CW'(1);

  assign in_ready_int = !out_valid_reg || bus.out_ready;
  assign accept       = bus.in_valid && in_ready_int;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= MIN2_INIT;
      acc_ovf_reg   <= 1'b0;
      beat_cnt_reg  <= '0;
      out_reg       <= '0;
      out_ovf_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && bus.out_ready) begin
        out_valid_reg <= 1'b0;
      end
      if (accept) begin
        if (bus.in_last) begin
          // Retire-and-load in one cycle: this overrides the clear above.
          out_reg       <= merged;
          out_ovf_reg   <= merged_ovf;
          out_valid_reg <= 1'b1;
          acc_reg       <= MIN2_INIT;
          acc_ovf_reg   <= 1'b0;
          beat_cnt_reg  <= '0;
        end else begin
          acc_reg       <= merged;
          acc_ovf_reg   <= merged_ovf;
          beat_cnt_reg  <= beat_cnt_next;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_int;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_min1  = out_reg.min1;
  assign bus.out_min2  = out_reg.min2;
  assign bus.out_idx1  = out_reg.idx1;
  assign bus.out_sign  = out_reg.sign;
  assign bus.out_ovf   = out_ovf_reg;

endmodule

// File: tb/tb_cn_min2_stream.sv
// Bench for cn_min2_stream (BITS=8, P=4, DEG_MAX=32).
// A frame-level model turns the list of accepted elements into the expected
// result; a per-cycle compare process checks out_valid, in_ready and the
// result fields against it. Hand-computed literals pin the model and the
// one-cycle latency.
module tb_cn_min2_stream;

  typedef struct {
    int min1;
    int min2;
    int idx;
    int sign;
    int ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   checking = 1'b0;

  res_t exp_q[$];
  int   cur_mag[$];
  int   cur_pos[$];
  int   cur_sign = 0;
  int   cur_beat = 0;

  always #5 clk = ~clk;

  cn_min2_stream_if #(.P(4)) bus ();

  cn_min2_stream #(.P(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Expected result straight from the definitions: smallest magnitude, its
  // first position, the second order statistic, parity of signs.
  function automatic res_t model_frame();
    res_t r;
    int cnt;
    r.min1 = 127;
    r.min2 = 127;
    r.idx  = 0;
    r.sign = cur_sign;
    r.ovf  = 0;
    foreach (cur_mag[i]) begin
      if (cur_mag[i] < r.min1) r.min1 = cur_mag[i];
      if (cur_pos[i] >= 32) r.ovf = 1;
    end
    cnt = 0;
    foreach (cur_mag[i]) begin
      if (cur_mag[i] == r.min1) begin
        if (cnt == 0 && r.min1 < 127) r.idx = (cur_pos[i] > 31) ? 31 : cur_pos[i];
        cnt++;
      end
    end
    if (cnt >= 2) begin
      r.min2 = r.min1;
    end else begin
      foreach (cur_mag[i]) begin
        if (cur_mag[i] != r.min1 && cur_mag[i] < r.min2) r.min2 = cur_mag[i];
      end
    end
    return r;
  endfunction

  function automatic void model_clear();
    cur_mag.delete();
    cur_pos.delete();
    cur_sign = 0;
    cur_beat = 0;
  endfunction

  function automatic void model_accept(input int vals[4], input logic [3:0] m, input logic last);
    logic signed [7:0] s;
    int sv;
    for (int l = 0; l < 4; l++) begin
      if (m[l]) begin
        s  = 8'(vals[l]);
        sv = int'(s);
        cur_mag.push_back((sv == -128) ? 127 : ((sv < 0) ? -sv : sv));
        cur_pos.push_back(cur_beat * 4 + l);
        if (sv < 0) cur_sign = cur_sign ^ 1;
      end
    end
    cur_beat++;
    if (last) begin
      exp_q.push_back(model_frame());
      model_clear();
    end
  endfunction

  task automatic send_beat(input int v0, input int v1, input int v2, input int v3,
                           input logic [3:0] m, input logic last);
    int vals[4];
    int waits;
    vals = '{v0, v1, v2, v3};
    @(negedge clk);
    bus.out_ready = 1'b1;
    for (int l = 0; l < 4; l++) bus.in_data[l] = 8'(vals[l]);
    bus.in_mask  = m;
    bus.in_last  = last;
    bus.in_valid = 1'b1;
    #1;
    waits = 0;
    while (!bus.in_ready && waits < 100) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, required 1", bus.in_ready, waits);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(vals, m, last);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
    end
  endtask

  task automatic check_res(input string name, input res_t got, input res_t want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got min1=%0d min2=%0d idx1=%0d sign=%0d ovf=%0d, required %0d %0d %0d %0d %0d",
               name, got.min1, got.min2, got.idx, got.sign, got.ovf,
               want.min1, want.min2, want.idx, want.sign, want.ovf);
    end
  endtask

  function automatic res_t dut_res();
    res_t r;
    r.min1 = int'(bus.out_min1);
    r.min2 = int'(bus.out_min2);
    r.idx  = int'(bus.out_idx1);
    r.sign = int'(bus.out_sign);
    r.ovf  = int'(bus.out_ovf);
    return r;
  endfunction

  // Called right after the last beat is accepted: the result must be up on the next cycle.
  task automatic check_dut(input string name, input res_t want);
    @(negedge clk);
    #3;
    total++;
    if (bus.out_valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_latency: out_valid=%0d one cycle after last, required 1", name, bus.out_valid);
    end
    check_res(name, dut_res(), want);
  endtask

  task automatic check_reset_state(input string name);
    total++;
    if (bus.out_valid !== 1'b0 || bus.out_min1 !== '0 || bus.out_min2 !== '0 ||
        bus.out_idx1 !== '0 || bus.out_sign !== 1'b0 || bus.out_ovf !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s: valid=%0d min1=%0d min2=%0d idx1=%0d sign=%0d ovf=%0d in_ready=%0d, required 0 0 0 0 0 0 1",
               name, bus.out_valid, bus.out_min1, bus.out_min2, bus.out_idx1, bus.out_sign,
               bus.out_ovf, bus.in_ready);
    end
  endtask

  // Per-cycle compare against the model queue.
  always begin
    bit exp_v;
    @(negedge clk);
    #2;
    if (checking && !rst) begin
      exp_v = (exp_q.size() != 0);
      total++;
      if (bus.out_valid !== exp_v) begin
        bad++;
        $display("FAIL out_valid: got %0d, required %0d", bus.out_valid, exp_v);
      end
      total++;
      if (bus.in_ready !== (!exp_v || bus.out_ready)) begin
        bad++;
        $display("FAIL in_ready: got %0d, required %0d", bus.in_ready, (!exp_v || bus.out_ready));
      end
      if (exp_v && bus.out_valid) begin
        check_res("out_fields", dut_res(), exp_q[0]);
        $display("result min1=%0d min2=%0d idx1=%0d sign=%0d ovf=%0d ready=%0d",
                 bus.out_min1, bus.out_min2, bus.out_idx1, bus.out_sign, bus.out_ovf, bus.out_ready);
      end
      if (exp_v && bus.out_ready) void'(exp_q.pop_front());
    end
  end

  initial begin
    int waits;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mask   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #3;
    check_reset_state("reset_state");
    rst = 1'b0;
    checking = 1'b1;

    // 1: two-beat frame
    send_beat(5, -3, 7, 2, 4'b1111, 1'b0);
    send_beat(9, -1, 4, 6, 4'b1111, 1'b1);
    check_res("t1_model", exp_q[$], '{1, 2, 5, 0, 0});
    check_dut("t1_dut", '{1, 2, 5, 0, 0});

    // 2: saturation and ties
    send_beat(-128, -128, 127, 127, 4'b1111, 1'b1);
    check_res("t2_model", exp_q[$], '{127, 127, 0, 0, 0});
    check_dut("t2_dut", '{127, 127, 0, 0, 0});

    // 3: masked lanes, back-to-back frames
    send_beat(-6, 1, 2, 3, 4'b0001, 1'b1);
    check_res("t3a_model", exp_q[$], '{6, 127, 0, 1, 0});
    send_beat(1, 1, 1, 1, 4'b0000, 1'b1);
    check_res("t3b_model", exp_q[$], '{127, 127, 0, 0, 0});
    check_dut("t3b_dut", '{127, 127, 0, 0, 0});

    // 4: backpressure, then retire and load in one cycle
    send_beat(10, -20, 30, 40, 4'b1111, 1'b1);
    bus.out_ready = 1'b0;
    check_res("t4a_model", exp_q[$], '{10, 20, 0, 1, 0});
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #3;
      total++;
      if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
        bad++;
        $display("FAIL t4_hold: in_ready=%0d out_valid=%0d, required 0 1", bus.in_ready, bus.out_valid);
      end
      check_res("t4_stable", dut_res(), '{10, 20, 0, 1, 0});
    end
    send_beat(8, 8, -2, 9, 4'b1111, 1'b1);
    check_res("t4b_model", exp_q[$], '{2, 8, 2, 1, 0});
    check_dut("t4b_dut", '{2, 8, 2, 1, 0});

    // 5: nine full beats overflow DEG_MAX, next frame clean
    for (int b = 0; b < 9; b++) begin
      int v[4];
      for (int l = 0; l < 4; l++) begin
        int pos;
        pos  = b * 4 + l;
        v[l] = (pos % 2 == 1) ? -(50 - pos) : (50 - pos);
      end
      send_beat(v[0], v[1], v[2], v[3], 4'b1111, (b == 8));
    end
    check_res("t5a_model", exp_q[$], '{15, 16, 31, 0, 1});
    check_dut("t5a_dut", '{15, 16, 31, 0, 1});
    send_beat(1, 2, 3, 4, 4'b1111, 1'b1);
    check_res("t5b_model", exp_q[$], '{1, 2, 0, 0, 0});
    check_dut("t5b_dut", '{1, 2, 0, 0, 0});

    // 6: reset mid-frame
    repeat (2) @(negedge clk);
    send_beat(1, 1, 1, 1, 4'b1111, 1'b0);
    send_beat(-1, 1, -1, 1, 4'b1111, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #3;
    check_reset_state("t6_reset_state");
    send_beat(3, 4, 5, 6, 4'b1111, 1'b1);
    check_res("t6_model", exp_q[$], '{3, 4, 0, 0, 0});
    check_dut("t6_dut", '{3, 4, 0, 0, 0});

    waits = 0;
    while (exp_q.size() != 0 && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d results pending, required 0", exp_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
